// File: rtl/frame_store_pkg.sv
// rtl/frame_store_pkg.sv - shared state encoding and sizing helpers for frame_store
package frame_store_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_REARM = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  // Pixels per frame
  function automatic int frame_n(input int rows, input int cols);
    return rows * cols;
  endfunction

  // Counters must be able to hold the value N itself
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

  // Bank address width, never narrower than one bit
  function automatic int addr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/frame_store_ram.sv
// rtl/frame_store_ram.sv - Depth x Width bank, synchronous write, asynchronous read
module frame_store_ram #(
  parameter int Depth     = 25,
  parameter int Width     = 12,
  parameter int AddrWidth = 5
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [AddrWidth-1:0] waddr,
  input  logic [Width-1:0]     wdata,
  input  logic [AddrWidth-1:0] raddr,
  output logic [Width-1:0]     rdata
);

  logic [Width-1:0] mem [Depth];

  // Write port; callers only assert we with an in-range address
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Addresses past the last entry read as zero instead of undefined storage
  assign rdata = (32'(raddr) < Depth) ? mem[raddr] : '0;

endmodule

// File: rtl/frame_store.sv
// rtl/frame_store.sv - image/result store and host streaming for conv2d (optional FRAME_STORE_ERR_EN)
import frame_store_pkg::*;

module frame_store #(
  parameter int AddressBitWidth = 17,
  parameter int DataBitWidth    = 12,
  parameter int NoOfRows        = 5,
  parameter int NoOfColumns     = 5,
  parameter int WriteBase       = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       load_valid,
  input  logic [DataBitWidth-1:0]    load_data,
  output logic                       load_ready,
  output logic                       conv_start,
  input  logic [AddressBitWidth-1:0] ReadAddress,
  output logic [DataBitWidth-1:0]    ReadData,
  input  logic [AddressBitWidth-1:0] WriteAddress,
  input  logic [DataBitWidth-1:0]    WriteData,
  input  logic                       WriteEnable,
  output logic                       drain_valid,
  output logic [DataBitWidth-1:0]    drain_data,
  input  logic                       drain_ready,
  output logic                       busy,
  output logic                       done,
  output logic                       err
);

  localparam int N   = frame_n(NoOfRows, NoOfColumns);
  localparam int CW  = cnt_width(N);
  localparam int RAW = addr_width(N);
  localparam logic [CW-1:0]              LAST = CW'(N - 1);
  localparam logic [AddressBitWidth-1:0] AN   = AddressBitWidth'(N);
  localparam logic [AddressBitWidth-1:0] WB   = AddressBitWidth'(WriteBase);
  localparam logic [AddressBitWidth-1:0] WEND = AddressBitWidth'(WriteBase + N);

  state_t                  state;
  logic [CW-1:0]           load_cnt;
  logic [CW-1:0]           wr_cnt;
  logic [CW-1:0]           drain_cnt;
  logic [CW-1:0]           drain_idx;
  logic                    load_xfer;
  logic                    drain_xfer;
  logic                    wr_in_range;
  logic                    res_we;
  logic                    frame_start;
  logic [DataBitWidth-1:0] img_rdata;
  logic [DataBitWidth-1:0] res_rdata;

  assign load_xfer   = (state == S_LOAD) && load_valid && load_ready;
  assign drain_xfer  = drain_valid && drain_ready;
  assign wr_in_range = (WriteAddress >= WB) && (WriteAddress < WEND);
  assign res_we      = (state == S_RUN) && WriteEnable && wr_in_range;
  // A start coinciding with the done pulse belongs to the frame just finished
  assign frame_start = (state == S_IDLE) && start && !done;
  // Look one pixel ahead on a drain transfer so drain_data is ready next cycle
  assign drain_idx   = drain_xfer ? drain_cnt + CW'(1) : drain_cnt;

  frame_store_ram #(.Depth(N), .Width(DataBitWidth), .AddrWidth(RAW)) u_image (
    .clk   (clk),
    .we    (load_xfer),
    .waddr (RAW'(load_cnt)),
    .wdata (load_data),
    .raddr (RAW'(ReadAddress)),
    .rdata (img_rdata)
  );

  frame_store_ram #(.Depth(N), .Width(DataBitWidth), .AddrWidth(RAW)) u_result (
    .clk   (clk),
    .we    (res_we),
    .waddr (RAW'(WriteAddress - WB)),
    .wdata (WriteData),
    .raddr (RAW'(drain_idx)),
    .rdata (res_rdata)
  );

  // Engine reads are combinational; out-of-frame addresses return zero
  assign ReadData = (ReadAddress < AN) ? img_rdata : '0;

  // Frame sequencer with all host/engine handshakes registered alongside the state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      load_cnt    <= '0;
      wr_cnt      <= '0;
      drain_cnt   <= '0;
      load_ready  <= 1'b0;
      conv_start  <= 1'b0;
      drain_valid <= 1'b0;
      drain_data  <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      conv_start <= 1'b0;
      done       <= 1'b0;
      case (state)
        S_IDLE: begin
          if (frame_start) begin
            state      <= S_LOAD;
            load_cnt   <= '0;
            wr_cnt     <= '0;
            drain_cnt  <= '0;
            load_ready <= 1'b1;
            busy       <= 1'b1;
          end
        end
        S_LOAD: begin
          if (load_xfer) begin
            load_cnt <= load_cnt + CW'(1);
            if (load_cnt == LAST) begin
              state      <= S_RUN;
              load_ready <= 1'b0;
              conv_start <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (res_we) begin
            wr_cnt <= wr_cnt + CW'(1);
            if (wr_cnt == LAST) begin
              state      <= S_REARM;
              conv_start <= 1'b1;
            end
          end
        end
        S_REARM: begin
          state       <= S_DRAIN;
          drain_valid <= 1'b1;
          drain_data  <= res_rdata;
        end
        S_DRAIN: begin
          if (drain_xfer) begin
            drain_cnt <= drain_cnt + CW'(1);
            if (drain_cnt == LAST) begin
              state       <= S_IDLE;
              drain_valid <= 1'b0;
              busy        <= 1'b0;
              done        <= 1'b1;
            end else begin
              drain_data <= res_rdata;
            end
          end
        end
        default: begin
          state       <= S_IDLE;
          load_ready  <= 1'b0;
          drain_valid <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

`ifdef FRAME_STORE_ERR_EN
  // Sticky flag for engine writes that land outside the result window
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if (frame_start) begin
      err <= 1'b0;
    end else if ((state == S_RUN) && WriteEnable && !wr_in_range) begin
      err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_frame_store.sv
// tb/tb_frame_store.sv - randomized self-checking bench for frame_store
`timescale 1ns/1ps
module tb_frame_store;

  localparam int AW = 17;
  localparam int DW = 12;
  localparam int R  = 5;
  localparam int C  = 5;
  localparam int WB = 1;
  localparam int N  = R * C;

`ifdef FRAME_STORE_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          load_valid;
  logic [DW-1:0] load_data;
  logic          load_ready;
  logic          conv_start;
  logic [AW-1:0] ReadAddress;
  logic [DW-1:0] ReadData;
  logic [AW-1:0] WriteAddress;
  logic [DW-1:0] WriteData;
  logic          WriteEnable;
  logic          drain_valid;
  logic [DW-1:0] drain_data;
  logic          drain_ready;
  logic          busy;
  logic          done;
  logic          err;

  always #5 clk = ~clk;

  frame_store #(
    .AddressBitWidth(AW), .DataBitWidth(DW), .NoOfRows(R), .NoOfColumns(C), .WriteBase(WB)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
    .conv_start(conv_start),
    .ReadAddress(ReadAddress), .ReadData(ReadData),
    .WriteAddress(WriteAddress), .WriteData(WriteData), .WriteEnable(WriteEnable),
    .drain_valid(drain_valid), .drain_data(drain_data), .drain_ready(drain_ready),
    .busy(busy), .done(done), .err(err)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: the two banks as plain arrays plus the expected error flag
  logic [DW-1:0] img [N];
  logic [DW-1:0] res [N];
  logic          exp_err = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic reset_values(input string tag);
    check({tag, ".load_ready"},  32'(load_ready),  0);
    check({tag, ".conv_start"},  32'(conv_start),  0);
    check({tag, ".drain_valid"}, 32'(drain_valid), 0);
    check({tag, ".busy"},        32'(busy),        0);
    check({tag, ".done"},        32'(done),        0);
    check({tag, ".err"},         32'(err),         0);
  endtask

  task automatic load_frame(input bit rand_valid, input bit ramp);
    int  k = 0;
    int  t = 0;
    int  rdy = 0;
    int  cs = 0;
    bit  was_ready;
    for (int i = 0; i < N; i++) img[i] = ramp ? DW'(i + 1) : DW'($urandom);
    check("idle_busy", 32'(busy), 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    exp_err = 1'b0;
    check("load_busy", 32'(busy), 1);
    check("err_cleared_on_start", 32'(err), 0);
    while (k < N && t < 400) begin
      load_valid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
      load_data  = load_valid ? img[k] : DW'($urandom);
      was_ready  = load_ready;
      if (load_ready) rdy++;
      if (conv_start) cs++;
      @(negedge clk);
      t++;
      if (load_valid && was_ready) k++;
    end
    load_valid = 1'b0;
    check("load_transfers", 32'(k), N);
    check("load_ready_every_load_cycle", 32'(rdy), 32'(t));
    if (!rand_valid) check("load_ready_cycle_count", 32'(rdy), N);
    check("no_conv_start_during_load", 32'(cs), 0);
    check("conv_start_after_load", 32'(conv_start), 1);
    check("load_ready_after_load", 32'(load_ready), 0);
  endtask

  task automatic read_sweep(input int extra);
    logic [AW-1:0] a;
    logic [DW-1:0] e;
    for (int i = 0; i < N + 2 + extra; i++) begin
      a = (i < N + 2) ? AW'(i) : AW'($urandom_range(0, (1 << AW) - 1));
      e = (a < AW'(N)) ? img[a] : '0;
      ReadAddress = a;
      #1;
      check("read_data", 32'(ReadData), 32'(e));
    end
    @(negedge clk);
  endtask

  task automatic stray_write(input logic [AW-1:0] a);
    WriteEnable  = 1'b1;
    WriteAddress = a;
    WriteData    = DW'($urandom);
    @(negedge clk);
    WriteEnable  = 1'b0;
  endtask

  // Drives `limit` in-range writes; a full frame ends at the REARM negedge
  task automatic run_writes(input bit strays, input bit rnd, input int limit);
    int order [N];
    int j, tmp;
    logic [DW-1:0] d;
    for (int i = 0; i < N; i++) order[i] = i;
    if (rnd) begin
      for (int i = N - 1; i > 0; i--) begin
        j = $urandom_range(0, i);
        tmp = order[i]; order[i] = order[j]; order[j] = tmp;
      end
    end
    if (strays) begin
      stray_write(AW'(0));
      stray_write(AW'(WB + N));
      if (rnd) stray_write(AW'($urandom_range(WB + N, (1 << AW) - 1)));
      exp_err = ERR_EN;
    end
    for (int i = 0; i < limit; i++) begin
      if (rnd && $urandom_range(0, 3) == 0) begin
        WriteEnable = 1'b0;
        @(negedge clk);
      end
      d = rnd ? DW'($urandom) : DW'(100 + order[i]);
      WriteEnable  = 1'b1;
      WriteAddress = AW'(order[i] + WB);
      WriteData    = d;
      res[order[i]] = d;
      @(negedge clk);
    end
    WriteEnable = 1'b0;
    if (limit == N) begin
      check("rearm_conv_start", 32'(conv_start), 1);
      check("rearm_no_drain", 32'(drain_valid), 0);
      check("rearm_busy", 32'(busy), 1);
      check("err_flag", 32'(err), 32'(exp_err));
    end
  endtask

  // mode 0: always ready, 1: ready 1-0-0-1 repeating, 2: random ready
  task automatic drain_frame(input int mode);
    int idx = 0;
    int t = 0;
    drain_ready  = 1'b0;
    WriteEnable  = 1'b1;
    WriteAddress = AW'(WB + N - 1);
    WriteData    = DW'($urandom);
    @(negedge clk);
    while (idx < N && t < 400) begin
      WriteData = DW'($urandom);
      check("drain_valid", 32'(drain_valid), 1);
      check("drain_data", 32'(drain_data), 32'(res[idx]));
      check("done_not_early", 32'(done), 0);
      case (mode)
        0:       drain_ready = 1'b1;
        1:       drain_ready = (t % 4 == 0) || (t % 4 == 3);
        default: drain_ready = 1'($urandom_range(0, 1));
      endcase
      @(negedge clk);
      t++;
      if (drain_ready) idx++;
    end
    WriteEnable = 1'b0;
    drain_ready = 1'b0;
    check("drain_transfers", 32'(idx), N);
    if (mode == 0) check("drain_back_to_back", 32'(t), N);
    check("done_pulse", 32'(done), 1);
    check("idle_after_drain", 32'(busy), 0);
    check("drain_valid_off", 32'(drain_valid), 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_with_done_ignored", 32'(busy), 0);
    check("done_one_cycle", 32'(done), 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; load_valid = 1'b0; load_data = '0;
    ReadAddress = '0; WriteAddress = '0; WriteData = '0; WriteEnable = 1'b0;
    drain_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset_values("reset");
    rst = 1'b0;
    @(negedge clk);

    // Ramp frame, in-order writes 100..124, free-flowing drain
    load_frame(1'b0, 1'b1);
    @(negedge clk);
    check("conv_start_one_cycle", 32'(conv_start), 0);
    read_sweep(0);
    run_writes(1'b0, 1'b0, N);
    drain_frame(0);

    // Stray writes around the window, stalled drain pattern
    load_frame(1'b0, 1'b1);
    run_writes(1'b1, 1'b0, N);
    drain_frame(1);

    // Reset in the middle of RUN, then a clean frame
    load_frame(1'b1, 1'b0);
    run_writes(1'b0, 1'b1, 10);
    rst = 1'b1;
    #1;
    reset_values("midrun_reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    load_frame(1'b0, 1'b0);
    read_sweep(4);
    run_writes(1'b0, 1'b1, N);
    drain_frame(0);

    // Fully randomized frames
    for (int f = 0; f < 4; f++) begin
      load_frame(1'b1, 1'b0);
      read_sweep(4);
      run_writes(f[0], 1'b1, N);
      drain_frame(2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
